step3_action_select: RTL
========================

// Module: step3_action_select
// PURPOSE
//  Consumes step2's per-action back-projected vectors gamma_action_belief[a][i][s].
//  For each belief point i, selects the action whose vector has the largest dot
//  product with point_belief[i], and emits the winning vector as the new alpha
//  vector for that point.
//  Processes serially, one (belief, action) pair per cycle. Feeds the alpha set
//  of the next PBVI iteration and reports a convergence flag.
// PARAMETERS
//  W         16  data width of alpha/belief entries (unsigned; belief is Q0.16)
//  N_ACTION  3   actions per belief (action index is 2 bits)
//  N_BELIEF  16  belief points (index is 4 bits)
//  N_STATE   2   fixed; the dot product is hard-wired to 2 terms
// PORTS
//  clk                 in   1          clock
//  rst_n               in   1          reset; asynchronous, active-low
//  en                  in   1          start pulse (step2 en_step3)
//  gamma_action_belief in   [3][16][2]x16  step2 output, sampled on start
//  point_belief        in   [16][2]x16 belief points, sampled on start
//  busy                out  1          high while computing
//  done                out  1          one-cycle pulse when all outputs are valid
//  alpha_new           out  [16][2]x16 selected vector per belief point
//  best_action         out  [16]x2     argmax action per belief point
//  best_value          out  [16]x16    max dot, saturated to [31:16]
//  converged           out  1          best_action unchanged vs previous run
// BEHAVIOUR
//  Reset: all outputs 0; FSM to IDLE; prev_valid = 0.
//  FSM states: IDLE, CALC, DONE.
//   - IDLE: en=1 -> snapshot both inputs into internal regs; i=0, a=0; go to CALC.
//   - CALC: one pair (i, a) per cycle; a counts 0..2, then i increments.
//     Leaves CALC after (i=15, a=2).
//   - DONE: done=1 for exactly one cycle; go to IDLE.
//  Start-to-done latency: en sampled at edge E0 -> done high after E49
//   (48 CALC cycles + 1 DONE cycle).
//  busy: 1 in CALC and DONE, 0 in IDLE.
//  en while busy: restarts from the snapshot step in any state, i.e. the
//   current run is aborted. Outputs hold last committed values;
//   converged is updated only at done.
//  Per-cycle dot product: 33-bit unsigned, no truncation before compare:
//   dot = g[a][i][0]*b[i][0] + g[a][i][1]*b[i][1]
//  Running max: if a==0 or dot > max, then max <= dot and arg <= a.
//   The comparison is strict, so on ties the lowest action index wins.
//  Commit at a==2, using the final argmax including the current cycle:
//   - alpha_new[i] <= g[arg][i]
//   - best_action[i] <= arg
//   - best_value[i] <= dot_max[32] ? 16'hFFFF : dot_max[31:16]
//   Outputs for points not yet committed keep their previous values.
//  Convergence: a per-run flag `diff` is set if any committed best_action differs
//   from its prior value.
//   - At DONE: converged <= prev_valid & ~diff; then prev_valid <= 1.
//   - The first run after reset always reports converged = 0.
//  Reset mid-operation: async clear to reset values; the partial run is discarded.
// TESTING
//  - Action 1 vectors all {0x8000,0x8000}, others 0, belief {0x8000,0x8000}:
//    en -> done after 49 cycles; best_action=1 for all i;
//    best_value=0x8000; alpha_new={0x8000,0x8000}.
//  - All three actions identical vectors -> best_action=0 everywhere (tie rule).
//  - Belief i = {0xFFFF,0} with action 2 larger in s0 only -> best_action=2.
//    Belief i = {0,0xFFFF} with action 0 larger in s1 -> best_action=0.
//  - Run the same inputs twice -> converged=0 after the 1st done, 1 after the 2nd.
//    Change one point's winner on a 3rd run -> converged=0.
//  - g=0xFFFF for all entries, b={0xFFFF,0xFFFF} -> dot[32]=1;
//    best_value saturates to 0xFFFF.
//  - Pulse en at cycle 20 of a run -> done comes 49 cycles after the 2nd en only.
//    Assert rst_n low mid-run -> all outputs 0, busy=0.

Source files
------------

// File: rtl/step3_action_select.sv
// PBVI step 3: for each belief point, pick the action vector with the largest
// dot product against that point and commit it as the new alpha vector.
module step3_action_select #(
  parameter int W        = 16,
  parameter int N_ACTION = 3,
  parameter int N_BELIEF = 16,
  parameter int N_STATE  = 2
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  i_en,
  input  logic [N_ACTION*N_BELIEF*N_STATE*W-1:0] i_gamma_action_belief,
  input  logic [N_BELIEF*N_STATE*W-1:0]          i_point_belief,
  output logic                                  o_busy,
  output logic                                  o_done,
  output logic [N_BELIEF*N_STATE*W-1:0]          o_alpha_new,
  output logic [N_BELIEF*2-1:0]                  o_best_action,
  output logic [N_BELIEF*W-1:0]                  o_best_value,
  output logic                                  o_converged
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [1:0] LAST_A = 2'(N_ACTION - 1);
  localparam logic [3:0] LAST_I = 4'(N_BELIEF - 1);

  state_t r_state, w_nextState;

  logic [N_ACTION*N_BELIEF*N_STATE*W-1:0] r_gamma;
  logic [N_BELIEF*N_STATE*W-1:0]          r_belief;
  logic [3:0]                             r_i;
  logic [1:0]                             r_a;
  logic [2*W:0]                           r_max;
  logic [1:0]                             r_arg;
  logic                                   r_diff;
  logic                                   r_prevValid;
  logic                                   r_done;
  logic                                   r_converged;
  logic [N_BELIEF*N_STATE*W-1:0]          r_alpha;
  logic [N_BELIEF*2-1:0]                  r_bestAction;
  logic [N_BELIEF*W-1:0]                  r_bestValue;

  logic [W-1:0]   w_g0, w_g1, w_b0, w_b1;
  logic [2*W-1:0] w_prod0, w_prod1;
  logic [2*W:0]   w_dot, w_maxFinal;
  logic [1:0]     w_argFinal;
  logic           w_last;
  int             w_curBase, w_selBase, w_ptBase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  // A start pulse wins in every state and aborts whatever run is in flight.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    w_nextState = IDLE;
      CALC:    if (w_last) w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
    if (i_en) w_nextState = CALC;
  end

  always_comb begin
    w_curBase  = ((int'(r_a) * N_BELIEF + int'(r_i)) * N_STATE) * W;
    w_ptBase   = int'(r_i) * N_STATE * W;
    w_g0       = r_gamma[w_curBase +: W];
    w_g1       = r_gamma[w_curBase + W +: W];
    w_b0       = r_belief[w_ptBase +: W];
    w_b1       = r_belief[w_ptBase + W +: W];
    w_prod0    = w_g0 * w_b0;
    w_prod1    = w_g1 * w_b1;
    w_dot      = {1'b0, w_prod0} + {1'b0, w_prod1};
    w_maxFinal = r_max;
    w_argFinal = r_arg;
    if (r_a == 2'd0 || w_dot > r_max) begin
      w_maxFinal = w_dot;
      w_argFinal = r_a;
    end
    w_selBase  = ((int'(w_argFinal) * N_BELIEF + int'(r_i)) * N_STATE) * W;
    w_last     = (r_i == LAST_I) && (r_a == LAST_A);
  end

  // Datapath: snapshot on start, scan (i, a) pairs, commit each point when a is last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gamma      <= '0;
      r_belief     <= '0;
      r_i          <= '0;
      r_a          <= '0;
      r_max        <= '0;
      r_arg        <= '0;
      r_diff       <= 1'b0;
      r_prevValid  <= 1'b0;
      r_done       <= 1'b0;
      r_converged  <= 1'b0;
      r_alpha      <= '0;
      r_bestAction <= '0;
      r_bestValue  <= '0;
    end else begin
      r_done <= 1'b0;
      if (i_en) begin
        r_gamma  <= i_gamma_action_belief;
        r_belief <= i_point_belief;
        r_i      <= '0;
        r_a      <= '0;
        r_diff   <= 1'b0;
      end else begin
        case (r_state)
          CALC: begin
            r_max <= w_maxFinal;
            r_arg <= w_argFinal;
            if (r_a == LAST_A) begin
              r_alpha[w_ptBase +: N_STATE*W] <= r_gamma[w_selBase +: N_STATE*W];
              r_bestAction[int'(r_i)*2 +: 2] <= w_argFinal;
              r_bestValue[int'(r_i)*W +: W]  <= w_maxFinal[2*W] ? {W{1'b1}}
                                                                : w_maxFinal[2*W-1:W];
              if (w_argFinal != r_bestAction[int'(r_i)*2 +: 2]) r_diff <= 1'b1;
              r_a <= '0;
              r_i <= r_i + 4'd1;
            end else begin
              r_a <= r_a + 2'd1;
            end
          end
          DONE: begin
            r_done      <= 1'b1;
            r_converged <= r_prevValid & ~r_diff;
            r_prevValid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign o_busy        = (r_state != IDLE);
  assign o_done        = r_done;
  assign o_alpha_new   = r_alpha;
  assign o_best_action = r_bestAction;
  assign o_best_value  = r_bestValue;
  assign o_converged   = r_converged;

endmodule
